// File: rtl/vga_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_game_ctrl
// Purpose  : Scheduler for the VGA display datapath. Debounces the mode and
//            game buttons, chooses one of the display patterns, derives the
//            once-per-frame motion enable and sequences the breakout game
//            (idle -> serve -> play -> lost/won) while tracking lives and
//            destroyed blocks.
// Ports    : clk, reset (sync, active-low)
//            mode_btn, btn_l, btn_r      raw board buttons
//            vertiacl_counter            VGA vertical counter
//            ball_lost, block_hit        datapath event pulses
//            pattern_sel, move_en, serve, board_l, board_r,
//            game_state, lives, blocks_left   registered outputs
// Revision : 1.0 - initial release
// ============================================================================
module vga_game_ctrl #(
  parameter int DEB_CYCLES   = 50000,
  parameter int NUM_PATTERNS = 6,
  parameter int GAME_PATTERN = 5,
  parameter int LIVES        = 3,
  parameter int NUM_BLOCKS   = 4,
  parameter int SPEED_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_btn,
  input  logic                  btn_l,
  input  logic                  btn_r,
  input  logic [9:0]            vertiacl_counter,
  input  logic                  ball_lost,
  input  logic [NUM_BLOCKS-1:0] block_hit,
  output logic [2:0]            pattern_sel,
  output logic                  move_en,
  output logic                  serve,
  output logic                  board_l,
  output logic                  board_r,
  output logic [2:0]            game_state,
  output logic [1:0]            lives,
  output logic [2:0]            blocks_left
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_WON   = 3'd4
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);
  localparam logic [2:0]  PAT_LAST  = 3'(NUM_PATTERNS - 1);
  localparam logic [2:0]  PAT_GAME  = 3'(GAME_PATTERN);
  localparam logic [1:0]  LIVES_INI = 2'(LIVES);
  localparam logic [2:0]  BLK_INI   = 3'(NUM_BLOCKS);
  localparam logic [3:0]  DIV_LAST  = 4'(SPEED_DIV - 1);

  // Button index: 0 = mode, 1 = left, 2 = right
  logic [2:0]  raw;
  logic [2:0]  sync1, sync2, level, level_q;
  logic [15:0] deb_cnt [3];
  logic [2:0]  press;

  assign raw   = {btn_r, btn_l, mode_btn};
  assign press = level & ~level_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Frame start = vertical counter returning to zero
  logic [9:0] vert_q;
  logic [3:0] div_cnt;
  logic       frame_p, step_p;

  assign frame_p = (vertiacl_counter == 10'd0) && (vert_q != 10'd0);
  assign step_p  = frame_p && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      vert_q  <= '0;
      div_cnt <= '0;
    end else begin
      vert_q <= vertiacl_counter;
      if (frame_p) div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end
  end

  // Only blocks not yet destroyed count as new hits
  state_t                state;
  logic [NUM_BLOCKS-1:0] hit_mask, new_hits;
  logic [2:0]            hit_cnt, blocks_after;
  logic [1:0]            lives_after;

  always_comb begin
    new_hits = block_hit & ~hit_mask;
    hit_cnt  = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) hit_cnt = hit_cnt + 3'(new_hits[i]);
    blocks_after = blocks_left - hit_cnt;
    lives_after  = lives - 2'd1;
  end

  assign game_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pattern_sel <= '0;
      state       <= ST_IDLE;
      lives       <= LIVES_INI;
      blocks_left <= BLK_INI;
      hit_mask    <= '0;
      move_en     <= 1'b0;
      serve       <= 1'b0;
      board_l     <= 1'b0;
      board_r     <= 1'b0;
    end else begin
      move_en <= 1'b0;
      serve   <= 1'b0;
      board_l <= 1'b0;
      board_r <= 1'b0;

      if (press[0]) pattern_sel <= (pattern_sel == PAT_LAST) ? 3'd0 : pattern_sel + 3'd1;

      if (pattern_sel != PAT_GAME) begin
        move_en <= step_p;
        state   <= ST_IDLE;
      end else if (press[0]) begin
        // Leaving the game pattern abandons the current game
        state       <= ST_IDLE;
        lives       <= LIVES_INI;
        blocks_left <= BLK_INI;
        hit_mask    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (press[1] || press[2]) begin
              state <= ST_SERVE;
              serve <= 1'b1;
            end
          end
          ST_SERVE: state <= ST_PLAY;
          ST_PLAY: begin
            move_en     <= step_p;
            // Both buttons held cancel each other out
            board_l     <= step_p & level[1] & ~level[2];
            board_r     <= step_p & level[2] & ~level[1];
            hit_mask    <= hit_mask | new_hits;
            blocks_left <= blocks_after;
            if ((new_hits != '0) && (blocks_after == 3'd0)) begin
              state <= ST_WON;
            end else if (ball_lost) begin
              lives <= lives_after;
              if (lives_after == 2'd0) begin
                state <= ST_LOST;
              end else begin
                state <= ST_SERVE;
                serve <= 1'b1;
              end
            end
          end
          ST_LOST, ST_WON: begin
            if (press[1] || press[2]) begin
              state       <= ST_IDLE;
              lives       <= LIVES_INI;
              blocks_left <= BLK_INI;
              hit_mask    <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_game_ctrl
// Purpose  : Directed self-checking bench for vga_game_ctrl (DEB_CYCLES=4,
//            SPEED_DIV=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_game_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [9:0] vertiacl_counter = 10'd524;
  logic       ball_lost = 1'b0;
  logic [3:0] block_hit = 4'd0;
  logic [2:0] pattern_sel, game_state, blocks_left;
  logic       move_en, serve, board_l, board_r;
  logic [1:0] lives;

  int passed = 0;
  int total  = 0;

  vga_game_ctrl #(
    .DEB_CYCLES(DEB), .NUM_PATTERNS(6), .GAME_PATTERN(5),
    .LIVES(3), .NUM_BLOCKS(4), .SPEED_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .btn_l(btn_l), .btn_r(btn_r),
    .vertiacl_counter(vertiacl_counter), .ball_lost(ball_lost), .block_hit(block_hit),
    .pattern_sel(pattern_sel), .move_en(move_en), .serve(serve),
    .board_l(board_l), .board_r(board_r), .game_state(game_state),
    .lives(lives), .blocks_left(blocks_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int which, input logic val);
    case (which)
      0: mode_btn = val;
      1: btn_l    = val;
      default: btn_r = val;
    endcase
  endtask

  task automatic press_btn(input int which);
    step_edge();
    set_btn(which, 1'b1);
    repeat (10) step_edge();
    set_btn(which, 1'b0);
    repeat (10) step_edge();
    @(negedge clk);
  endtask

  task automatic pulse_lost();
    step_edge();
    ball_lost = 1'b1;
    step_edge();
    ball_lost = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_hit(input logic [3:0] hit, input logic lost);
    step_edge();
    block_hit = hit;
    ball_lost = lost;
    step_edge();
    block_hit = 4'd0;
    ball_lost = 1'b0;
    @(negedge clk);
  endtask

  task automatic sweep(input int frames, output int n_move, output int n_l,
                       output int n_r, output int n_double);
    logic prev;
    n_move = 0; n_l = 0; n_r = 0; n_double = 0; prev = 1'b0;
    for (int f = 0; f < frames; f++) begin
      for (int v = 0; v < 525; v++) begin
        step_edge();
        vertiacl_counter = 10'(v);
        @(negedge clk);
        if (move_en) n_move++;
        if (move_en && prev) n_double++;
        if (board_l) n_l++;
        if (board_r) n_r++;
        prev = move_en;
      end
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_pattern"}, 32'(pattern_sel), 0);
    check({pfx, "_state"},   32'(game_state), 0);
    check({pfx, "_lives"},   32'(lives), 3);
    check({pfx, "_blocks"},  32'(blocks_left), 4);
    check({pfx, "_move_en"}, 32'(move_en), 0);
    check({pfx, "_serve"},   32'(serve), 0);
    check({pfx, "_board_l"}, 32'(board_l), 0);
    check({pfx, "_board_r"}, 32'(board_r), 0);
  endtask

  initial begin
    int nm, nl, nr, nd;

    // Reset
    repeat (3) step_edge();
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst");

    // Pattern 0: move_en follows the divided frame pulse
    sweep(2, nm, nl, nr, nd);
    check("pat0_move_cnt", 32'(nm), 1);
    check("pat0_move_double", 32'(nd), 0);

    // First mode press with exact latency: output changes DEB+3 edges after the edge
    step_edge();
    mode_btn = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk);
    check("mode_lat_early", 32'(pattern_sel), 0);
    @(posedge clk);
    @(negedge clk);
    check("mode_lat_exact", 32'(pattern_sel), 1);
    step_edge();
    mode_btn = 1'b0;
    repeat (10) step_edge();
    @(negedge clk);
    for (int p = 2; p <= 5; p++) begin
      press_btn(0);
      check($sformatf("mode_press_%0d", p), 32'(pattern_sel), 32'(p));
    end

    // Pattern 5 IDLE: no motion
    sweep(2, nm, nl, nr, nd);
    check("idle_move_cnt", 32'(nm), 0);

    // Two-cycle glitch on btn_l must not register
    step_edge();
    btn_l = 1'b1;
    repeat (2) step_edge();
    btn_l = 1'b0;
    repeat (12) step_edge();
    @(negedge clk);
    check("glitch_state", 32'(game_state), 0);

    // Stable btn_l press: IDLE -> SERVE exactly DEB+3 edges later, then PLAY
    step_edge();
    btn_l = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk);
    check("start_lat_early", 32'(game_state), 0);
    @(posedge clk);
    @(negedge clk);
    check("start_serve_state", 32'(game_state), 1);
    check("start_serve_pulse", 32'(serve), 1);
    @(posedge clk);
    @(negedge clk);
    check("start_play_state", 32'(game_state), 2);
    check("start_serve_low", 32'(serve), 0);
    step_edge();
    btn_l = 1'b0;
    repeat (10) step_edge();
    @(negedge clk);

    // PLAY: one move_en per two frames, single cycle
    sweep(4, nm, nl, nr, nd);
    check("play_move_cnt", 32'(nm), 2);
    check("play_move_double", 32'(nd), 0);
    check("play_board_none", 32'(nl + nr), 0);

    // Hold left: board_l only with move_en
    step_edge();
    btn_l = 1'b1;
    repeat (10) step_edge();
    @(negedge clk);
    check("hold_l_state", 32'(game_state), 2);
    sweep(2, nm, nl, nr, nd);
    check("hold_l_board_l", 32'(nl), 1);
    check("hold_l_board_r", 32'(nr), 0);
    // Both held: neither direction
    step_edge();
    btn_r = 1'b1;
    repeat (10) step_edge();
    sweep(2, nm, nl, nr, nd);
    check("hold_lr_move", 32'(nm), 1);
    check("hold_lr_board", 32'(nl + nr), 0);
    step_edge();
    btn_l = 1'b0;
    btn_r = 1'b0;
    repeat (10) step_edge();
    @(negedge clk);

    // Block hits, repeated hits ignored
    pulse_hit(4'b0001, 1'b0);
    check("hit1_blocks", 32'(blocks_left), 3);
    pulse_hit(4'b0001, 1'b0);
    check("hit_dup_blocks", 32'(blocks_left), 3);
    pulse_hit(4'b0110, 1'b0);
    check("hit2_blocks", 32'(blocks_left), 1);
    check("hit2_state", 32'(game_state), 2);

    // One life lost, re-serve
    pulse_lost();
    check("lost1_lives", 32'(lives), 2);
    check("lost1_state", 32'(game_state), 1);
    check("lost1_serve", 32'(serve), 1);
    @(posedge clk);
    @(negedge clk);
    check("lost1_replay", 32'(game_state), 2);

    // Final block and ball_lost together: WON, lives unchanged
    pulse_hit(4'b1000, 1'b1);
    check("won_state", 32'(game_state), 4);
    check("won_lives", 32'(lives), 2);
    check("won_blocks", 32'(blocks_left), 0);

    // Press in WON reloads and returns to IDLE
    press_btn(2);
    check("won_exit_state", 32'(game_state), 0);
    check("won_exit_lives", 32'(lives), 3);
    check("won_exit_blocks", 32'(blocks_left), 4);

    // New game, lose all lives
    press_btn(2);
    check("game2_state", 32'(game_state), 2);
    for (int k = 2; k >= 0; k--) begin
      pulse_lost();
      check($sformatf("loss_lives_%0d", k), 32'(lives), 32'(k));
      check($sformatf("loss_state_%0d", k), 32'(game_state), (k == 0) ? 32'd3 : 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
    end
    check("lost_hold_state", 32'(game_state), 3);

    // Events ignored outside PLAY
    pulse_hit(4'b0001, 1'b1);
    check("lost_ignore_lives", 32'(lives), 0);
    check("lost_ignore_blocks", 32'(blocks_left), 4);

    // Exit LOST, play again down to one life
    press_btn(1);
    check("lost_exit_state", 32'(game_state), 0);
    check("lost_exit_lives", 32'(lives), 3);
    press_btn(1);
    pulse_lost();
    repeat (2) @(posedge clk);
    pulse_lost();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("game3_lives", 32'(lives), 1);
    check("game3_state", 32'(game_state), 2);
    pulse_hit(4'b0001, 1'b0);
    check("game3_blocks", 32'(blocks_left), 3);

    // Mode press in PLAY: wrap to pattern 0, game aborted and reloaded
    press_btn(0);
    check("abort_pattern", 32'(pattern_sel), 0);
    check("abort_state", 32'(game_state), 0);
    check("abort_lives", 32'(lives), 3);
    check("abort_blocks", 32'(blocks_left), 4);

    // Back to the game, down to one life, then reset mid-PLAY
    for (int p = 1; p <= 5; p++) press_btn(0);
    check("return_pattern", 32'(pattern_sel), 5);
    press_btn(2);
    pulse_lost();
    repeat (2) @(posedge clk);
    pulse_lost();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_lives", 32'(lives), 1);
    check("pre_rst_state", 32'(game_state), 2);
    step_edge();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
